mem_sram_ctrl: RTL and testbench

- Sequences each 32-bit data-memory access from the MEM stage onto an external 16-bit asynchronous SRAM as two half-word phases.
- Holds `ready` low for the whole access so the hazard/freeze logic stalls every pipeline register, MEM-stage register included, until the word completes.
- Read data is returned registered, for the MEM-stage register to capture on the cycle `ready` rises.

---
 rtl/mem_sram_ctrl.sv | 117 +++++++++++
 tb/tb_mem_sram_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit access into two
// half-word phases on an external 16-bit asynchronous SRAM.
module mem_sram_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               MEM_r_en,
    input  logic               MEM_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int unsigned      CNT_W    = 4;
    localparam int unsigned      WORD_W   = SRAM_AW - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] word;
    logic [15:0]       wdata_hi;
    logic              op_wr;

    logic              req;
    logic [WORD_W-1:0] word_c;

    assign req = MEM_r_en | MEM_w_en;

    // Word index relative to the SRAM window; upper bits wrap away.
    assign word_c = WORD_W'((address - 32'(BASE_ADDR)) >> 2);

    // Freeze the pipeline from the request cycle until the word is complete.
    assign ready = ~(req & (state != DONE));

    // Sequencer; SRAM pins are registered with the values for the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            word        <= '0;
            wdata_hi    <= '0;
            op_wr       <= 1'b0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state       <= LOW;
                        cnt         <= '0;
                        word        <= word_c;
                        wdata_hi    <= wdata[31:16];
                        op_wr       <= MEM_w_en;
                        sram_addr   <= {word_c, 1'b0};
                        sram_dq_out <= MEM_w_en ? wdata[15:0] : 16'h0000;
                        sram_dq_oe  <= MEM_w_en;
                        sram_we_n   <= ~MEM_w_en;
                    end
                end
                LOW: begin
                    if (cnt == CNT_LAST) begin
                        if (!op_wr) begin
                            rdata[15:0] <= sram_dq_in;
                        end
                        state       <= HIGH;
                        cnt         <= '0;
                        sram_addr   <= {word, 1'b1};
                        sram_dq_out <= op_wr ? wdata_hi : 16'h0000;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (cnt == CNT_LAST) begin
                        if (!op_wr) begin
                            rdata[31:16] <= sram_dq_in;
                        end
                        state       <= DONE;
                        cnt         <= '0;
                        sram_addr   <= '0;
                        sram_dq_out <= '0;
                        sram_dq_oe  <= 1'b0;
                        sram_we_n   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: two instances (1 and 3 wait cycles) on behavioural
// SRAMs, checked against a transaction-level memory/rdata model.
module tb_mem_sram_ctrl;

    localparam int unsigned AW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          rst_n;
    logic [1:0]          r_en, w_en;
    logic [1:0][31:0]    addr_i, wdata_i, rdata_o;
    logic [1:0]          ready_o, oe_o, we_n_o;
    logic [1:0][AW-1:0]  sa_o;
    logic [1:0][15:0]    dq_out_o, dq_in_i;

    logic [15:0] mem0 [0:(1<<AW)-1];
    logic [15:0] mem1 [0:(1<<AW)-1];
    logic          clr, pl_en, pl_sel, inj_en;
    logic [AW-1:0] pl_a;
    logic [15:0]   pl_v, inj_val;

    int checks = 0;
    int failures = 0;

    logic [15:0] ref_mem [int unsigned];
    logic [31:0] ref_rdata [2];

    mem_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_AW(AW)) u_w1 (
        .clk(clk), .rst_n(rst_n[0]), .MEM_r_en(r_en[0]), .MEM_w_en(w_en[0]),
        .address(addr_i[0]), .wdata(wdata_i[0]), .rdata(rdata_o[0]), .ready(ready_o[0]),
        .sram_addr(sa_o[0]), .sram_dq_out(dq_out_o[0]), .sram_dq_in(dq_in_i[0]),
        .sram_dq_oe(oe_o[0]), .sram_we_n(we_n_o[0])
    );

    mem_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(3), .SRAM_AW(AW)) u_w3 (
        .clk(clk), .rst_n(rst_n[1]), .MEM_r_en(r_en[1]), .MEM_w_en(w_en[1]),
        .address(addr_i[1]), .wdata(wdata_i[1]), .rdata(rdata_o[1]), .ready(ready_o[1]),
        .sram_addr(sa_o[1]), .sram_dq_out(dq_out_o[1]), .sram_dq_in(dq_in_i[1]),
        .sram_dq_oe(oe_o[1]), .sram_we_n(we_n_o[1])
    );

    // Behavioural SRAMs: a write lands for each cycle we_n is low outside reset.
    assign dq_in_i[0] = mem0[sa_o[0]];
    assign dq_in_i[1] = inj_en ? inj_val : mem1[sa_o[1]];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem0[i] = 16'h0;
                mem1[i] = 16'h0;
            end
        end
        if (pl_en) begin
            if (pl_sel) mem1[pl_a] = pl_v;
            else        mem0[pl_a] = pl_v;
        end
        if (rst_n[0] && !we_n_o[0]) mem0[sa_o[0]] = dq_out_o[0];
        if (rst_n[1] && !we_n_o[1]) mem1[sa_o[1]] = dq_out_o[1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Half-word SRAM address of byte address a: word offset from 1024, wrapped to 17 bits.
    function automatic logic [AW-1:0] ha_of(input logic [31:0] a, input bit hi);
        logic [31:0] w;
        w = (a - 32'd1024) / 32'd4;
        return AW'((w % 32'h20000) * 32'd2 + 32'(hi));
    endfunction

    function automatic int unsigned rkey(input int d, input logic [AW-1:0] ha);
        return (32'(d) << AW) + 32'(ha);
    endfunction

    function automatic logic [15:0] ref_rd(input int d, input logic [AW-1:0] ha);
        return ref_mem.exists(rkey(d, ha)) ? ref_mem[rkey(d, ha)] : 16'h0;
    endfunction

    function automatic logic [15:0] sram_rd(input int d, input logic [AW-1:0] ha);
        return (d == 0) ? mem0[ha] : mem1[ha];
    endfunction

    task automatic preload(input int d, input logic [AW-1:0] ha, input logic [15:0] v);
        pl_sel = (d != 0);
        pl_a   = ha;
        pl_v   = v;
        pl_en  = 1'b1;
        @(posedge clk); #1;
        pl_en  = 1'b0;
        ref_mem[rkey(d, ha)] = v;
    endtask

    task automatic idle_check(input int d);
        chk("idle_pins", {28'h0, ready_o[d], oe_o[d], we_n_o[d], 1'b0}, 32'h0000_000A);
        chk("idle_addr", 32'(sa_o[d]), 32'h0);
        chk("idle_dq", 32'(dq_out_o[d]), 32'h0);
        chk("rdata_hold", rdata_o[d], ref_rdata[d]);
    endtask

    task automatic idle(input int n);
        r_en = '0;
        w_en = '0;
        repeat (n) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        idle_check(0);
        idle_check(1);
        @(posedge clk); #1;
    endtask

    // One access starting in an IDLE cycle; leaves the DUT back in IDLE at posedge+1.
    task automatic run_access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, input bit inj, output logic [31:0] got);
        int            w, low, wec, oec, buserr;
        bit            xs, done, hi;
        logic [AW-1:0] lo_a, hi_a;
        logic [31:0]   exp_rd;
        w = (d == 0) ? 1 : 3;
        low = 0; wec = 0; oec = 0; buserr = 0; xs = 0; done = 0;
        lo_a = ha_of(a, 1'b0);
        hi_a = ha_of(a, 1'b1);
        r_en[d] = rd; w_en[d] = wr; addr_i[d] = a; wdata_i[d] = wd;
        for (int c = 0; c < 64; c++) begin
            if (inj) inj_val = 16'hA000 + 16'(c);
            @(negedge clk);
            if ($isunknown({ready_o[d], oe_o[d], we_n_o[d], sa_o[d], dq_out_o[d], rdata_o[d]})) xs = 1;
            if (ready_o[d]) begin
                done = 1;
                break;
            end
            low++;
            if (c == 0) begin
                if (sa_o[d] !== '0 || we_n_o[d] !== 1'b1) buserr++;
            end else begin
                hi = (c > w);
                if (sa_o[d] !== (hi ? hi_a : lo_a)) buserr++;
                if (wr && dq_out_o[d] !== (hi ? wd[31:16] : wd[15:0])) buserr++;
            end
            if (!we_n_o[d]) wec++;
            if (oe_o[d]) oec++;
            @(posedge clk); #1;
        end
        if (!done) chk("timeout", 32'h0, 32'h1);
        if (sa_o[d] !== '0 || we_n_o[d] !== 1'b1 || oe_o[d] !== 1'b0) buserr++;
        got = rdata_o[d];
        if (wr) begin
            ref_mem[rkey(d, lo_a)] = wd[15:0];
            ref_mem[rkey(d, hi_a)] = wd[31:16];
            exp_rd = ref_rdata[d];
            chk("sram_write", {sram_rd(d, hi_a), sram_rd(d, lo_a)}, wd);
        end else if (inj) begin
            exp_rd = {16'hA000 + 16'(2 * w), 16'hA000 + 16'(w)};
        end else begin
            exp_rd = {ref_rd(d, hi_a), ref_rd(d, lo_a)};
        end
        ref_rdata[d] = exp_rd;
        chk("ready_low", 32'(low), 32'(2 * w + 1));
        chk("we_cycles", 32'(wec), wr ? 32'(2 * w) : 32'h0);
        chk("oe_cycles", 32'(oec), wr ? 32'(2 * w) : 32'h0);
        chk("bus_seq", 32'(buserr), 32'h0);
        chk("no_x", 32'(xs), 32'h0);
        chk("rdata", got, exp_rd);
        @(posedge clk); #1;
        r_en[d] = 1'b0;
        w_en[d] = 1'b0;
    endtask

    typedef struct {
        int          d;
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] got, a;
        int          op, d;

        tbl[0]  = '{0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h00000000};
        tbl[1]  = '{0, 1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF};
        tbl[2]  = '{0, 1'b1, 1'b0, 32'd1029, 32'h0,        32'hDEADBEEF};
        tbl[3]  = '{0, 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 32'hDEADBEEF};
        tbl[4]  = '{0, 1'b1, 1'b0, 32'd1040, 32'h0,        32'hCAFEF00D};
        tbl[5]  = '{0, 1'b0, 1'b1, 32'd1200, 32'h11112222, 32'hCAFEF00D};
        tbl[6]  = '{0, 1'b1, 1'b0, 32'd1200, 32'h0,        32'h11112222};
        tbl[7]  = '{0, 1'b0, 1'b1, 32'd1020, 32'h0BADF00D, 32'h11112222};
        tbl[8]  = '{0, 1'b1, 1'b0, 32'd1020, 32'h0,        32'h0BADF00D};
        tbl[9]  = '{1, 1'b1, 1'b0, 32'd1024, 32'h0,        32'h12345678};
        tbl[10] = '{1, 1'b0, 1'b1, 32'd1032, 32'h55AA33CC, 32'h12345678};
        tbl[11] = '{1, 1'b1, 1'b0, 32'd1032, 32'h0,        32'h55AA33CC};

        rst_n = 2'b00; r_en = '0; w_en = '0; addr_i = '0; wdata_i = '0;
        clr = 1'b1; pl_en = 1'b0; pl_sel = 1'b0; pl_a = '0; pl_v = '0;
        inj_en = 1'b0; inj_val = '0;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        idle_check(0);
        idle_check(1);
        @(posedge clk); #1;
        rst_n = 2'b11;
        preload(1, AW'(0), 16'h5678);
        preload(1, AW'(1), 16'h1234);

        // Directed vectors, issued back to back per instance.
        for (int i = 0; i < 12; i++) begin
            run_access(tbl[i].d, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, 1'b0, got);
            chk("tbl_rdata", got, tbl[i].exp);
        end
        chk("map_lo_beef", 32'(mem0[2]), 32'h0000BEEF);
        chk("map_hi_dead", 32'(mem0[3]), 32'h0000DEAD);
        chk("wrap_lo", 32'(mem0[AW'(18'h3FFFE)]), 32'h0000F00D);
        chk("wrap_hi", 32'(mem0[AW'(18'h3FFFF)]), 32'h00000BAD);
        idle(2);

        // Sample timing: injected bus values expose which wait-state cycle is captured.
        inj_en = 1'b1;
        run_access(1, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, got);
        inj_en = 1'b0;
        chk("sample_cycle", got, 32'hA006A003);
        idle(1);

        // Reset during the HIGH phase of a write.
        preload(0, AW'(39), 16'h7777);
        addr_i[0] = 32'd1100; wdata_i[0] = 32'hAAAA5555; w_en[0] = 1'b1; r_en[0] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mw_low_we_n", 32'(we_n_o[0]), 32'h0);
        @(posedge clk); #1;
        rst_n[0] = 1'b0;
        @(posedge clk); #1;
        chk("mw_rst_pins", {30'h0, oe_o[0], we_n_o[0]}, 32'h1);
        chk("mw_rst_addr", 32'(sa_o[0]), 32'h0);
        chk("mw_rst_dq", 32'(dq_out_o[0]), 32'h0);
        chk("mw_rst_rdata", rdata_o[0], 32'h0);
        chk("mw_rst_ready_req", 32'(ready_o[0]), 32'h0);
        w_en[0] = 1'b0;
        #1;
        chk("mw_rst_ready", 32'(ready_o[0]), 32'h1);
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        @(posedge clk); #1;
        chk("mw_hi_kept", 32'(mem0[39]), 32'h00007777);
        chk("mw_lo_done", 32'(mem0[38]), 32'h00005555);
        ref_mem[rkey(0, AW'(38))] = 16'h5555;
        ref_rdata[0] = '0;
        idle(1);

        // Randomized traffic against the transaction model.
        for (int n = 0; n < 150; n++) begin
            d  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 2));
            case ($urandom_range(0, 7))
                0:       a = $urandom;
                1:       a = 32'd1020 - 32'd4 * $urandom_range(0, 3);
                default: a = 32'd1024 + 32'd4 * $urandom_range(0, 31) + $urandom_range(0, 3);
            endcase
            run_access(d, op != 1, op != 0, a, $urandom, 1'b0, got);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
